// File: rtl/grid_color_reader_pkg.sv
// Shared definitions for the grid colour reader: colour RAM geometry, RRRGGGBB
// field masks, screen limits, controller state encoding and cell coordinate helper.
package grid_color_reader_pkg;

    localparam int COLOR_RAM_AW = 8;
    localparam int GRID_COLS    = 64;

    localparam logic [7:0] COLOR_R_MASK = 8'hE0;
    localparam logic [7:0] COLOR_G_MASK = 8'h1C;
    localparam logic [7:0] COLOR_B_MASK = 8'h03;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RD        = 3'd3,
        ST_RD_WAIT   = 3'd4,
        ST_DRAW      = 3'd5,
        ST_NEXT_COL  = 3'd6,
        ST_NEXT_ROW  = 3'd7
    } state_t;

    // Screen coordinate of the top-left pixel of a cell along one axis.
    function automatic logic [9:0] cell_origin(input logic [7:0] idx,
                                               input int unsigned offset,
                                               input int unsigned scale);
        return 10'(offset) + 10'(idx) * 10'(scale);
    endfunction

endpackage

// File: rtl/grid_color_reader_if.sv
// VGA pixel-write port: coordinates and colour qualified by a req/ack handshake.
interface grid_color_reader_if;

    logic [9:0] vga_x;
    logic [9:0] vga_y;
    logic [7:0] vga_color;
    logic       vga_req;
    logic       vga_ack;

    modport master (
        output vga_x,
        output vga_y,
        output vga_color,
        output vga_req,
        input  vga_ack
    );

    modport slave (
        input  vga_x,
        input  vga_y,
        input  vga_color,
        input  vga_req,
        output vga_ack
    );

endinterface

// File: rtl/grid_color_reader_pixel_block_emitter.sv
// Emits one SCALE x SCALE block of a single colour over the VGA req/ack port,
// raster order within the block, one pixel per accepted ack.
module pixel_block_emitter #(
    parameter int SCALE = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_go,
    input  logic [9:0]           i_base_x,
    input  logic [9:0]           i_base_y,
    input  logic [7:0]           i_color,
    output logic                 o_block_done,
    grid_color_reader_if.master  vga
);

    localparam int CW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCALE - 1);

    logic          r_req;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic [9:0]    r_base_x;
    logic [7:0]    r_color;
    logic [CW-1:0] r_dx;
    logic [CW-1:0] r_dy;
    logic          r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_base_x <= '0;
            r_color  <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_go && !r_req) begin
                r_req    <= 1'b1;
                r_base_x <= i_base_x;
                r_x      <= i_base_x;
                r_y      <= i_base_y;
                r_color  <= i_color;
                r_dx     <= '0;
                r_dy     <= '0;
            end else if (r_req && vga.vga_ack) begin
                // Coordinates only move on an accepted pixel, so they hold while unacked.
                if (r_dx == LAST) begin
                    if (r_dy == LAST) begin
                        r_req  <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_dx <= '0;
                        r_x  <= r_base_x;
                        r_dy <= r_dy + CW'(1);
                        r_y  <= r_y + 10'd1;
                    end
                end else begin
                    r_dx <= r_dx + CW'(1);
                    r_x  <= r_x + 10'd1;
                end
            end
        end
    end

    assign vga.vga_req   = r_req;
    assign vga.vga_x     = r_x;
    assign vga.vga_y     = r_y;
    assign vga.vga_color = r_color;
    assign o_block_done  = r_done;

endmodule

// File: rtl/grid_color_reader.sv
// Row-at-a-time heat-map drawer: requests a grid row, reads its colours back from
// the colour RAM and paints each cell as a SCALE x SCALE block, wrapping after ROWS.
module grid_color_reader
    import grid_color_reader_pkg::*;
#(
    parameter int COLS     = GRID_COLS,
    parameter int ROWS     = 64,
    parameter int SCALE    = 4,
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 0,
    parameter int RD_LAT   = 2
) (
    input  logic                    clk_50,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    done_write_sig,
    output logic                    comp_allow,
    output logic [COLOR_RAM_AW-1:0] rd_addr,
    input  logic [7:0]              rd_data,
    output logic [7:0]              row_idx,
    output logic                    frame_done,
    grid_color_reader_if.master     vga
);

    state_t                  r_state;
    logic [7:0]              r_col;
    logic [7:0]              r_row_idx;
    logic                    r_done_latch;
    logic [3:0]              r_wait_cnt;
    logic [7:0]              r_pix_color;
    logic                    r_go;
    logic                    r_comp_allow;
    logic                    r_frame_done;
    logic [COLOR_RAM_AW-1:0] r_rd_addr;

    logic                    w_block_done;
    logic [9:0]              w_base_x;
    logic [9:0]              w_base_y;

    assign w_base_x = cell_origin(r_col, X_OFFSET, SCALE);
    assign w_base_y = cell_origin(r_row_idx, Y_OFFSET, SCALE);

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row_idx    <= '0;
            r_done_latch <= 1'b0;
            r_wait_cnt   <= '0;
            r_pix_color  <= '0;
            r_go         <= 1'b0;
            r_comp_allow <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_addr    <= '0;
        end else begin
            r_comp_allow <= 1'b0;
            r_frame_done <= 1'b0;
            r_go         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state      <= ST_REQ;
                        r_comp_allow <= 1'b1;
                    end
                end
                // A done pulse landing on the request cycle belongs to an older write.
                ST_REQ: begin
                    r_done_latch <= 1'b0;
                    r_state      <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (r_done_latch) begin
                        r_col   <= '0;
                        r_state <= ST_RD;
                    end else if (done_write_sig) begin
                        r_done_latch <= 1'b1;
                    end
                end
                ST_RD: begin
                    r_rd_addr  <= COLOR_RAM_AW'(r_col);
                    r_wait_cnt <= '0;
                    r_state    <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (r_wait_cnt == 4'(RD_LAT)) begin
                        r_pix_color <= rd_data;
                        r_go        <= 1'b1;
                        r_state     <= ST_DRAW;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ST_DRAW: begin
                    if (w_block_done) begin
                        r_state <= ST_NEXT_COL;
                    end
                end
                ST_NEXT_COL: begin
                    if (r_col == 8'(COLS - 1)) begin
                        r_state <= ST_NEXT_ROW;
                    end else begin
                        r_col   <= r_col + 8'd1;
                        r_state <= ST_RD;
                    end
                end
                ST_NEXT_ROW: begin
                    if (r_row_idx == 8'(ROWS - 1)) begin
                        r_row_idx    <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row_idx <= r_row_idx + 8'd1;
                    end
                    // enable is only sampled here, so a dropped enable finishes the row first.
                    if (enable) begin
                        r_state      <= ST_REQ;
                        r_comp_allow <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pixel_block_emitter #(
        .SCALE (SCALE)
    ) u_emitter (
        .i_clk        (clk_50),
        .i_rst_n      (reset),
        .i_go         (r_go),
        .i_base_x     (w_base_x),
        .i_base_y     (w_base_y),
        .i_color      (r_pix_color),
        .o_block_done (w_block_done),
        .vga          (vga)
    );

    assign comp_allow = r_comp_allow;
    assign rd_addr    = r_rd_addr;
    assign row_idx    = r_row_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_grid_color_reader.sv
// Bench for grid_color_reader: colour RAM model, random VGA ack, and a
// per-row pixel-set reference built from the cell/scale geometry.
module tb_grid_color_reader;

    localparam int COLS   = 64;
    localparam int ROWS   = 8;
    localparam int SCALE  = 4;
    localparam int X_OFF  = 0;
    localparam int Y_OFF  = 0;
    localparam int RD_LAT = 2;
    localparam int PIX_PER_ROW = COLS * SCALE * SCALE;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       done_write_sig = 1'b0;
    logic       comp_allow;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] row_idx;
    logic       frame_done;

    grid_color_reader_if vif ();

    grid_color_reader #(
        .COLS(COLS), .ROWS(ROWS), .SCALE(SCALE),
        .X_OFFSET(X_OFF), .Y_OFFSET(Y_OFF), .RD_LAT(RD_LAT)
    ) dut (
        .clk_50         (clk_50),
        .reset          (reset),
        .enable         (enable),
        .done_write_sig (done_write_sig),
        .comp_allow     (comp_allow),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .row_idx        (row_idx),
        .frame_done     (frame_done),
        .vga            (vif)
    );

    always #10 clk_50 = ~clk_50;

    // Colour RAM: data for an address appears RD_LAT clocks after it is presented.
    logic [7:0] mem [256];
    logic [7:0] rd_pipe [RD_LAT];
    always @(posedge clk_50) begin
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    int ack_pct = 100;
    always @(posedge clk_50) begin
        #1;
        vif.vga_ack = ($urandom_range(0, 99) < ack_pct);
    end

    int cyc = 0;
    always @(posedge clk_50) cyc++;

    logic [9:0] px_x [$];
    logic [9:0] px_y [$];
    logic [7:0] px_c [$];
    int comp_cnt = 0, frame_cnt = 0, stab_err = 0, req_seen = 0;
    logic       prev_pend = 1'b0;
    logic [9:0] prev_x, prev_y;
    logic [7:0] prev_c;

    always @(negedge clk_50) begin
        if (comp_allow === 1'b1) comp_cnt++;
        if (frame_done === 1'b1) frame_cnt++;
        if (vif.vga_req === 1'b1) req_seen++;
        if (reset && prev_pend &&
            !(vif.vga_req === 1'b1 && vif.vga_x === prev_x &&
              vif.vga_y === prev_y && vif.vga_color === prev_c))
            stab_err++;
        if (vif.vga_req === 1'b1 && vif.vga_ack === 1'b1) begin
            px_x.push_back(vif.vga_x);
            px_y.push_back(vif.vga_y);
            px_c.push_back(vif.vga_color);
        end
        prev_pend = reset && (vif.vga_req === 1'b1) && (vif.vga_ack !== 1'b1);
        prev_x = vif.vga_x;
        prev_y = vif.vga_y;
        prev_c = vif.vga_color;
    end

    int checks = 0;
    int errors = 0;

    // Reference: every cell c of row r covers a SCALE x SCALE square of colour mem[c].
    function automatic int row_bad(input int start, input int row);
        logic [7:0] exp_c [int];
        bit seen [int];
        int bad = 0;
        int key;
        for (int c = 0; c < COLS; c++)
            for (int dy = 0; dy < SCALE; dy++)
                for (int dx = 0; dx < SCALE; dx++)
                    exp_c[(X_OFF + c*SCALE + dx) * 1024 + (Y_OFF + row*SCALE + dy)] = mem[c];
        if (px_x.size() - start != PIX_PER_ROW) bad++;
        for (int i = start; i < px_x.size(); i++) begin
            key = int'(px_x[i]) * 1024 + int'(px_y[i]);
            if (!exp_c.exists(key)) bad++;
            else begin
                if (seen.exists(key)) bad++;
                seen[key] = 1'b1;
                if (px_c[i] !== exp_c[key]) bad++;
            end
        end
        return bad;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < COLS; i++) mem[i] = 8'($urandom);
    endtask

    task automatic pulse_done();
        @(posedge clk_50); #1 done_write_sig = 1'b1;
        @(posedge clk_50); #1 done_write_sig = 1'b0;
    endtask

    task automatic wait_pixels(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_50);
            if (px_x.size() >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_row(output int s, output bit ok);
        s = px_x.size();
        fill_mem();
        pulse_done();
        wait_pixels(s + PIX_PER_ROW, 8000, ok);
        repeat (12) @(negedge clk_50);
    endtask

    // Releases reset with enable high and returns the clocks until comp_allow shows.
    task automatic release_and_time_req(output int lat);
        int cy;
        @(negedge clk_50);
        enable = 1'b1;
        reset  = 1'b1;
        cy  = cyc;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50);
            if (comp_allow === 1'b1) begin lat = cyc - cy; break; end
        end
    endtask

    task automatic test_reset();
        int lat, c0, r0;
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk_50);
        checks++;
        if ({comp_allow, rd_addr, row_idx, frame_done} !== 18'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got comp=%b addr=%0d row=%0d frame=%b, want all 0",
                     comp_allow, rd_addr, row_idx, frame_done);
        end
        checks++;
        if (vif.vga_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b want 0", vif.vga_req);
        end
        checks++;
        if ({vif.vga_x, vif.vga_y, vif.vga_color} !== 28'd0) begin
            errors++;
            $display("FAIL reset_pix: got x=%0d y=%0d c=%h want 0", vif.vga_x, vif.vga_y, vif.vga_color);
        end
        c0 = comp_cnt;
        r0 = req_seen;
        release_and_time_req(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL first_req_latency: got %0d clocks want 1", lat);
        end
        repeat (20) @(negedge clk_50);
        checks++;
        if (comp_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL single_req_pulse: got %0d pulses want 1", comp_cnt - c0);
        end
        checks++;
        if (req_seen !== r0) begin
            errors++;
            $display("FAIL no_draw_before_done: got %0d req cycles want 0", req_seen - r0);
        end
    endtask

    task automatic test_first_row();
        int s, c0, bad;
        bit ok;
        s = px_x.size();
        fill_mem();
        mem[0] = 8'hE0;
        mem[COLS-1] = 8'h03;
        c0 = comp_cnt;
        pulse_done();
        wait_pixels(s + PIX_PER_ROW, 6000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL row0_timeout: got %0d pixels want %0d", px_x.size() - s, PIX_PER_ROW);
        end else begin
            bad = 0;
            for (int dy = 0; dy < SCALE; dy++)
                for (int dx = 0; dx < SCALE; dx++)
                    if (px_x[s + dy*SCALE + dx] !== 10'(X_OFF + dx) ||
                        px_y[s + dy*SCALE + dx] !== 10'(Y_OFF + dy) ||
                        px_c[s + dy*SCALE + dx] !== 8'hE0) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL first_block: got %0d wrong pixels want 0", bad);
            end
            bad = 0;
            for (int dy = 0; dy < SCALE; dy++)
                for (int dx = 0; dx < SCALE; dx++) begin
                    int k = s + PIX_PER_ROW - SCALE*SCALE + dy*SCALE + dx;
                    if (px_x[k] !== 10'(X_OFF + (COLS-1)*SCALE + dx) ||
                        px_y[k] !== 10'(Y_OFF + dy) || px_c[k] !== 8'h03) bad++;
                end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL last_block: got %0d wrong pixels want 0", bad);
            end
        end
        repeat (30) @(negedge clk_50);
        bad = row_bad(s, 0);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL row0_pixels: got %0d discrepancies want 0", bad);
        end
        checks++;
        if (comp_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL row0_next_req: got %0d pulses want 1", comp_cnt - c0);
        end
        checks++;
        if (row_idx !== 8'd1) begin
            errors++;
            $display("FAIL row0_advance: got row_idx %0d want 1", row_idx);
        end
    endtask

    task automatic test_random_ack_enable_drop();
        int s, c0, st0, bad;
        bit ok;
        ack_pct = 30;
        s = px_x.size();
        st0 = stab_err;
        fill_mem();
        pulse_done();
        repeat (200) @(negedge clk_50);
        enable = 1'b0;
        c0 = comp_cnt;
        wait_pixels(s + PIX_PER_ROW, 20000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random_ack_timeout: got %0d pixels want %0d", px_x.size() - s, PIX_PER_ROW);
        end
        repeat (40) @(negedge clk_50);
        ack_pct = 100;
        bad = row_bad(s, 1);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL random_ack_pixels: got %0d discrepancies want 0", bad);
        end
        checks++;
        if (stab_err - st0 !== 0) begin
            errors++;
            $display("FAIL hold_while_unacked: got %0d changes want 0", stab_err - st0);
        end
        checks++;
        if (comp_cnt - c0 !== 0) begin
            errors++;
            $display("FAIL stop_after_row: got %0d requests want 0", comp_cnt - c0);
        end
        checks++;
        if (row_idx !== 8'd2) begin
            errors++;
            $display("FAIL row1_advance: got row_idx %0d want 2", row_idx);
        end
    endtask

    task automatic test_done_during_req();
        int s, r0, bad;
        bit ok;
        @(negedge clk_50);
        enable = 1'b1;
        @(posedge clk_50); #1 done_write_sig = 1'b1;
        @(negedge clk_50);
        checks++;
        if (comp_allow !== 1'b1) begin
            errors++;
            $display("FAIL req_cycle_align: got comp_allow %b want 1", comp_allow);
        end
        @(posedge clk_50); #1 done_write_sig = 1'b0;
        s  = px_x.size();
        r0 = req_seen;
        repeat (20) @(negedge clk_50);
        checks++;
        if (req_seen !== r0) begin
            errors++;
            $display("FAIL early_done_ignored: got %0d req cycles want 0", req_seen - r0);
        end
        fill_mem();
        pulse_done();
        wait_pixels(s + PIX_PER_ROW, 6000, ok);
        repeat (12) @(negedge clk_50);
        bad = row_bad(s, 2);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL late_done_row: got %0d discrepancies ok=%b want 0", bad, ok);
        end
    endtask

    task automatic test_frame_wrap();
        int s, f0, fmid, bad;
        bit ok;
        f0 = frame_cnt;
        bad = 0;
        fmid = 0;
        for (int r = 3; r < ROWS; r++) begin
            if (r == ROWS - 1) fmid = frame_cnt - f0;
            run_row(s, ok);
            if (!ok) bad++;
            bad += row_bad(s, r);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL frame_rows: got %0d discrepancies want 0", bad);
        end
        checks++;
        if (fmid !== 0) begin
            errors++;
            $display("FAIL frame_early: got %0d pulses before last row want 0", fmid);
        end
        checks++;
        if (frame_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL frame_pulse: got %0d pulses want 1", frame_cnt - f0);
        end
        checks++;
        if (row_idx !== 8'd0) begin
            errors++;
            $display("FAIL frame_wrap_row: got row_idx %0d want 0", row_idx);
        end
        run_row(s, ok);
        bad = row_bad(s, 0);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL wrapped_row_top: got %0d discrepancies ok=%b want 0", bad, ok);
        end
    endtask

    task automatic test_reset_mid_draw();
        int s, lat, bad;
        bit ok;
        bad = 0;
        for (int r = 1; r < 5; r++) begin
            run_row(s, ok);
            if (!ok) bad++;
        end
        s = px_x.size();
        fill_mem();
        pulse_done();
        wait_pixels(s + 10*SCALE*SCALE + 5, 6000, ok);
        @(posedge clk_50); #2;
        checks++;
        if (bad !== 0 || !ok || vif.vga_req !== 1'b1 || row_idx !== 8'd5) begin
            errors++;
            $display("FAIL pre_reset_state: got req=%b row=%0d ok=%b missed=%0d want req=1 row=5",
                     vif.vga_req, row_idx, ok, bad);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (vif.vga_req !== 1'b0) begin
            errors++;
            $display("FAIL async_req_drop: got %b want 0", vif.vga_req);
        end
        checks++;
        if (row_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_row_idx: got %0d want 0", row_idx);
        end
        repeat (3) @(negedge clk_50);
        release_and_time_req(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL restart_req_latency: got %0d clocks want 1", lat);
        end
        repeat (4) @(negedge clk_50);
        run_row(s, ok);
        bad = row_bad(s, 0);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL restart_row0: got %0d discrepancies ok=%b want 0", bad, ok);
        end
    endtask

    initial begin
        #(20 * 80000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_first_row();
        test_random_ack_enable_drop();
        test_done_during_req();
        test_frame_wrap();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
